// File: rtl/if_id_fifo_pkg.sv
// if_id_fifo_pkg: shared fetch/decode widths, the decode bubble encoding and the entry layout.
package if_id_fifo_pkg;
   localparam int PC_W = 32;
   localparam int INST_W = 32;
   localparam logic [INST_W-1:0] INST_NOP = 32'h0340_0000;
   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } entry_t;
endpackage

// File: rtl/if_id_fifo.sv
// if_id_fifo: fetch-to-decode buffer with valid/ready on both sides and flush on redirect.
module if_id_fifo
   import if_id_fifo_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PC_W-1:0]            in_pc,
   input  logic [INST_W-1:0]          in_inst,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_W-1:0]            out_pc,
   output logic [INST_W-1:0]          out_inst,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   entry_t mem_q [DEPTH];
   entry_t mem_d [DEPTH];
   entry_t head;
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] count_q, count_d;
   logic push, pop;
   // in_ready looks only at registered occupancy, so decode stalls never reach fetch combinationally
   always_comb begin
      in_ready  = ~rst & (count_q != CW'(DEPTH));
      out_valid = count_q != '0;
      push      = in_valid & in_ready & ~flush;
      pop       = out_valid & out_ready & ~flush;
      head      = mem_q[rp_q];
      out_pc    = out_valid ? head.pc : '0;
      out_inst  = out_valid ? head.inst : INST_NOP;
      count     = count_q;
      mem_d     = mem_q;
      if (push) mem_d[wp_q] = {in_pc, in_inst};
      wp_d      = flush ? '0 : wp_q + AW'(push);
      rp_d      = flush ? '0 : rp_q + AW'(pop);
      count_d   = flush ? '0 : count_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_if_id_fifo.sv
// tb_if_id_fifo: directed vector table plus a streamed wrap-around sequence with a small reference model.
module tb_if_id_fifo;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] in_pc, in_inst, out_pc, out_inst;
   logic [1:0]  count;
   int ntests = 0;
   int nfail = 0;

   localparam logic [31:0] NOP = 32'h0340_0000;

   typedef struct {
      logic        rst, flush, iv;
      logic [31:0] pc, inst;
      logic        ordy;
      logic        e_ir, e_ov;
      logic [31:0] e_pc, e_inst;
      logic [1:0]  e_cnt;
   } vec_t;
   vec_t vq[$];

   if_id_fifo #(.DEPTH(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, f, iv, input logic [31:0] pc, inst, input logic ordy,
                      input logic ir, ov, input logic [31:0] epc, einst, input logic [1:0] cnt);
      vec_t v;
      v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy;
      v.e_ir = ir; v.e_ov = ov; v.e_pc = epc; v.e_inst = einst; v.e_cnt = cnt;
      vq.push_back(v);
   endtask

   initial begin
      int mc, sent, recv, cyc;
      logic exp_ir, p, q;
      // rst flush iv pc inst ordy | in_ready out_valid out_pc out_inst count (before the edge)
      add(1, 0, 1, 32'h100, 32'h11, 0,        0, 0, 0, NOP, 0);
      add(1, 0, 1, 32'h100, 32'h11, 0,        0, 0, 0, NOP, 0);
      add(0, 0, 1, 32'h1c000000, 32'h02800405, 1, 1, 0, 0, NOP, 0);
      add(0, 0, 0, 0, 0, 1,                   1, 1, 32'h1c000000, 32'h02800405, 1);
      add(0, 0, 0, 0, 0, 0,                   1, 0, 0, NOP, 0);
      add(0, 0, 1, 32'h1c000000, 32'h13, 0,   1, 0, 0, NOP, 0);
      add(0, 0, 1, 32'h1c000004, 32'h100093, 0, 1, 1, 32'h1c000000, 32'h13, 1);
      add(0, 0, 1, 32'h1c000008, 32'h200113, 0, 0, 1, 32'h1c000000, 32'h13, 2);
      add(0, 0, 1, 32'h1c000008, 32'h200113, 0, 0, 1, 32'h1c000000, 32'h13, 2);
      add(0, 0, 1, 32'h1c000008, 32'h200113, 1, 0, 1, 32'h1c000000, 32'h13, 2);
      add(0, 0, 1, 32'h1c000008, 32'h200113, 1, 1, 1, 32'h1c000004, 32'h100093, 1);
      add(0, 0, 0, 0, 0, 0,                   1, 1, 32'h1c000008, 32'h200113, 1);
      add(0, 0, 1, 32'h1c00000c, 32'h300193, 0, 1, 1, 32'h1c000008, 32'h200113, 1);
      add(0, 1, 1, 32'hdead0000, 32'hbad, 1,  0, 1, 32'h1c000008, 32'h200113, 2);
      add(0, 0, 0, 0, 0, 1,                   1, 0, 0, NOP, 0);
      add(0, 0, 0, 0, 0, 1,                   1, 0, 0, NOP, 0);
      add(0, 0, 1, 32'h2000, 32'h2222, 0,     1, 0, 0, NOP, 0);
      add(1, 0, 1, 32'h3000, 32'h3333, 0,     0, 1, 32'h2000, 32'h2222, 1);
      add(0, 0, 0, 0, 0, 0,                   1, 0, 0, NOP, 0);

      rst = 1; flush = 0; in_valid = 0; in_pc = 0; in_inst = 0; out_ready = 0;
      @(posedge clk);
      foreach (vq[i]) begin
         @(negedge clk);
         rst = vq[i].rst; flush = vq[i].flush; in_valid = vq[i].iv;
         in_pc = vq[i].pc; in_inst = vq[i].inst; out_ready = vq[i].ordy;
         #1;
         check($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vq[i].e_ir});
         check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vq[i].e_ov});
         check($sformatf("v%0d out_pc", i), out_pc, vq[i].e_pc);
         check($sformatf("v%0d out_inst", i), out_inst, vq[i].e_inst);
         check($sformatf("v%0d count", i), {30'b0, count}, {30'b0, vq[i].e_cnt});
      end

      // stream 10 pcs through the pointer wrap with alternating out_ready
      mc = 0; sent = 0; recv = 0; cyc = 0;
      while (recv < 10 && cyc < 100) begin
         @(negedge clk);
         rst = 0; flush = 0;
         in_valid = sent < 10;
         in_pc = 32'h1c000000 + 32'(4 * sent);
         in_inst = 32'ha5000000 | 32'(sent);
         out_ready = cyc[0];
         #1;
         exp_ir = mc != 2;
         p = in_valid & exp_ir;
         q = (mc != 0) & out_ready;
         check("wrap in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
         check("wrap count", {30'b0, count}, 32'(mc));
         if (q) begin
            check("wrap out_pc", out_pc, 32'h1c000000 + 32'(4 * recv));
            check("wrap out_inst", out_inst, 32'ha5000000 | 32'(recv));
            recv++;
         end
         sent += int'(p);
         mc = mc + int'(p) - int'(q);
         cyc++;
      end
      check("wrap delivered", 32'(recv), 32'd10);
      @(negedge clk);
      in_valid = 0; out_ready = 0;
      #1;
      check("wrap drained", {31'b0, out_valid}, 32'd0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
